einstein_rst_ce_gen: RTL and testbench
======================================

// Module: einstein_rst_ce_gen
// PURPOSE
//   Reset sequencer and clock-enable generator that sits directly downstream of the system PLL.
//   It synchronises the PLL locked flag and an external reset request into clk_sys (20 MHz PLL output).
//   It holds system reset until lock has been stable for RST_HOLD cycles.
//   It then emits single-cycle clock enables for the CPU, PSG and FDC domains, all derived from clk_sys.
// PARAMETERS
//   RST_HOLD  1024  clk_sys cycles of stable lock required before reset release (>=1)
//   DIV_CPU   5     ce_cpu period in clk_sys cycles (20/5 = 4 MHz); >=1
//   DIV_PSG   10    ce_psg period (2 MHz); >=1
//   DIV_FDC   20    ce_fdc period (1 MHz); >=1
// PORTS
//   clk_sys      in   1  system clock, 20 MHz from PLL outclk_0
//   reset_n      in   1  synchronous, active-low block reset
//   pll_locked   in   1  PLL locked flag, asynchronous to clk_sys
//   ext_rst_req  in   1  user/OSD reset request, asynchronous, level; must be high >=2 clk_sys cycles
//   sys_rst_n    out  1  system reset to the core, active-low, registered
//   ce_cpu       out  1  CPU clock enable, one clk_sys cycle wide
//   ce_psg       out  1  PSG clock enable, one cycle wide
//   ce_fdc       out  1  FDC clock enable, one cycle wide
//   pll_lost     out  1  sticky flag: lock dropped after it was first seen; cleared only by reset_n
// BEHAVIOUR
//   - Reset state: when reset_n=0 at a clk_sys edge, the block clears everything on that edge:
//     - both 2-flop synchronisers
//     - the hold counter and all divider counters
//     - the state register, which goes to S_WAIT
//     - every output, which goes to 0 (sys_rst_n=0, ce_*=0, pll_lost=0)
//   - Synchronisers: pll_locked -> lock_s and ext_rst_req -> req_s, each through 2 flops. Both reset to 0.
//   - Define ok = lock_s & ~req_s.
//   - FSM:
//     - S_WAIT: hold_cnt=0. If ok, go to S_STRETCH.
//     - S_STRETCH: hold_cnt increments each cycle.
//       - If ~ok, go to S_WAIT and clear hold_cnt.
//       - Else if hold_cnt==RST_HOLD-1, go to S_RUN.
//     - S_RUN: if ~ok, go to S_WAIT.
//   - sys_rst_n is registered from next-state==S_RUN, so it changes on the same edge as the state.
//   - Timing, with edge 1 being the first edge that samples pll_locked=1 (ext_rst_req=0):
//     - lock_s is 1 after edge 2.
//     - S_STRETCH is entered at edge 3.
//     - sys_rst_n=1 after edge RST_HOLD+3.
//   - Lock loss or request in S_RUN: sys_rst_n=0 after the 3rd edge sampling the new input level. There is no debounce beyond the synchroniser.
//   - pll_lost is set on the edge where lock_s falls while in S_STRETCH or S_RUN. It is not set by req_s.
//   - Dividers:
//     - Each counter cnt_x runs 0..DIV_x-1 and wraps, only in S_RUN.
//     - Outside S_RUN, cnt_x is forced to 0 and ce_x=0.
//     - Cycle 0 is the first clk_sys cycle with sys_rst_n=1.
//     - ce_x is high exactly in cycles k*DIV_x-1, for k>=1 (period DIV_x, width 1).
//     - DIV_x=1 gives ce_x=1 in every S_RUN cycle.
//     - All dividers share cycle 0, so coincident pulses are deterministic: ce_fdc, ce_psg and ce_cpu all fire in cycle 19.
//   - Exit from S_RUN: on the edge that leaves S_RUN, all ce_* drop to 0 and counters clear, regardless of counter value. No partial pulse is emitted.
//   - Widths: hold_cnt is $clog2(RST_HOLD+1) bits; cnt_x is $clog2(DIV_x+1) bits. No counter saturates past its terminal value.
// TESTING
//   - T1 Power-up (RST_HOLD=16):
//     - Stimulus: reset_n=0 for 4 cycles, then 1; pll_locked=1 throughout.
//     - Required: sys_rst_n rises exactly 19 edges after reset_n release; all ce_*=0 before that.
//   - T2 Cadence (defaults):
//     - Required: ce_cpu in cycles 4,9,14,19; ce_psg in 9,19; ce_fdc in 19,39.
//     - Required: each pulse is 1 cycle wide; all three coincide in cycle 19.
//   - T3 Lock loss in RUN:
//     - Stimulus: pll_locked=0 for 3 cycles.
//     - Required: sys_rst_n=0 after the 3rd edge; ce_* stop that edge; pll_lost=1.
//     - Required: after relock, sys_rst_n rises 19 edges later (RST_HOLD=16).
//   - T4 Glitch during STRETCH:
//     - Stimulus: lock low for 2 cycles when hold_cnt=10.
//     - Required: return to S_WAIT; the full 16-cycle hold restarts after relock; pll_lost=1.
//   - T5 External request:
//     - Stimulus: ext_rst_req=1 for 5 cycles in RUN.
//     - Required: sys_rst_n low from the 3rd edge; release 16+3 edges after req falls (sampled); pll_lost stays 0.
//   - T6 Reset mid-operation:
//     - Stimulus: reset_n=0 for 1 cycle during RUN with pll_lost=1.
//     - Required: next edge gives sys_rst_n=0, ce_*=0, pll_lost=0; then the full sequence as in T1.

Source files
------------

// File: rtl/einstein_rst_ce_gen.sv
// Reset sequencer and clock-enable generator fed by the system PLL. It releases the core
// reset after a stable lock and generates the CPU/PSG/FDC enables from clk_sys.

module einstein_ce_div #(
  parameter int DIV = 5
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic run_cur,
  input  logic run_nxt,
  output logic ce
);
  localparam int W = $clog2(DIV + 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt, cnt_nxt;

  // Counter phase 0 always falls on the first run cycle, so every divider shares cycle 0.
  always_comb begin
    cnt_nxt = '0;
    if (run_cur && cnt != LAST) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (run_nxt) begin
      cnt <= cnt_nxt;
      ce  <= (cnt_nxt == LAST);
    end else begin
      cnt <= '0;
      ce  <= 1'b0;
    end
  end
endmodule

module einstein_rst_ce_gen #(
  parameter int RST_HOLD = 1024,
  parameter int DIV_CPU  = 5,
  parameter int DIV_PSG  = 10,
  parameter int DIV_FDC  = 20
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic ext_rst_req,
  output logic sys_rst_n,
  output logic ce_cpu,
  output logic ce_psg,
  output logic ce_fdc,
  output logic pll_lost
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HLAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {S_WAIT, S_STRETCH, S_RUN} state_t;

  state_t        state, state_nxt;
  logic          lock_m, lock_s, req_m, req_s;
  logic [HW-1:0] hold_cnt;
  logic          ok, run_cur, run_nxt, hold_inc, lost_set;

  assign ok = lock_s & ~req_s;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      req_m  <= 1'b0;
      req_s  <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
      req_m  <= ext_rst_req;
      req_s  <= req_m;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:    if (ok) state_nxt = S_STRETCH;
      S_STRETCH: begin
        if (!ok)                   state_nxt = S_WAIT;
        else if (hold_cnt == HLAST) state_nxt = S_RUN;
      end
      S_RUN:     if (!ok) state_nxt = S_WAIT;
      default:   state_nxt = S_WAIT;
    endcase
  end

  // lock_s falls on the edge where lock_m already holds the low sample.
  always_comb begin
    run_cur  = (state == S_RUN);
    run_nxt  = (state_nxt == S_RUN);
    hold_inc = (state == S_STRETCH) && (state_nxt == S_STRETCH);
    lost_set = (state != S_WAIT) && lock_s && !lock_m;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
      pll_lost  <= 1'b0;
    end else begin
      hold_cnt  <= hold_inc ? hold_cnt + 1'b1 : '0;
      sys_rst_n <= run_nxt;
      pll_lost  <= pll_lost | lost_set;
    end
  end

  einstein_ce_div #(.DIV(DIV_CPU)) u_div_cpu (
    .clk_sys(clk_sys), .reset_n(reset_n), .run_cur(run_cur), .run_nxt(run_nxt), .ce(ce_cpu)
  );
  einstein_ce_div #(.DIV(DIV_PSG)) u_div_psg (
    .clk_sys(clk_sys), .reset_n(reset_n), .run_cur(run_cur), .run_nxt(run_nxt), .ce(ce_psg)
  );
  einstein_ce_div #(.DIV(DIV_FDC)) u_div_fdc (
    .clk_sys(clk_sys), .reset_n(reset_n), .run_cur(run_cur), .run_nxt(run_nxt), .ce(ce_fdc)
  );
endmodule

// File: tb/tb_einstein_rst_ce_gen.sv
// Scoreboard bench: per-edge expectations come from a lock/request history model and are
// compared by an independent monitor; directed edge-count checks cover the power-up scenarios.

module tb_einstein_rst_ce_gen;
  localparam int RST_HOLD = 16;
  localparam int DIV_CPU  = 5;
  localparam int DIV_PSG  = 10;
  localparam int DIV_FDC  = 20;

  typedef struct packed {
    logic rst;
    logic cpu;
    logic psg;
    logic fdc;
    logic lost;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset_n, pll_locked, ext_rst_req;
  logic sys_rst_n, ce_cpu, ce_psg, ce_fdc, pll_lost;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  exp_t exp_q[$];

  // reference model state: input history and streak of usable edges
  int   streak  = 0;
  int   run_idx = 0;
  logic ok_d1 = 1'b0, ok_d2 = 1'b0, lk_d1 = 1'b0, lk_d2 = 1'b0;
  logic lost = 1'b0, rst_prev = 1'b0;

  einstein_rst_ce_gen #(
    .RST_HOLD(RST_HOLD), .DIV_CPU(DIV_CPU), .DIV_PSG(DIV_PSG), .DIV_FDC(DIV_FDC)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pll_locked(pll_locked), .ext_rst_req(ext_rst_req),
    .sys_rst_n(sys_rst_n), .ce_cpu(ce_cpu), .ce_psg(ce_psg), .ce_fdc(ce_fdc), .pll_lost(pll_lost)
  );

  always #25 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic act, input logic req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc, act, req);
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", nm, act, req);
  endtask

  // Output after the coming edge: the core sees inputs two edges late, runs once
  // RST_HOLD+1 consecutive usable edges have been seen, and enables fire on run
  // cycles k*DIV-1.
  task automatic model_edge(input logic r, input logic l, input logic q, output exp_t x);
    logic okf, fall, act_b;
    x = '0;
    if (!r) begin
      streak = 0; run_idx = 0; lost = 1'b0; rst_prev = 1'b0;
      ok_d1 = 1'b0; ok_d2 = 1'b0; lk_d1 = 1'b0; lk_d2 = 1'b0;
      return;
    end
    okf   = ok_d2;
    act_b = (streak >= 1);
    fall  = lk_d2 & ~lk_d1;
    streak = okf ? streak + 1 : 0;
    if (fall && act_b) lost = 1'b1;
    x.rst   = (streak >= RST_HOLD + 1);
    run_idx = x.rst ? (rst_prev ? run_idx + 1 : 0) : 0;
    rst_prev = x.rst;
    x.cpu  = x.rst && ((run_idx + 1) % DIV_CPU == 0);
    x.psg  = x.rst && ((run_idx + 1) % DIV_PSG == 0);
    x.fdc  = x.rst && ((run_idx + 1) % DIV_FDC == 0);
    x.lost = lost;
    ok_d2 = ok_d1; ok_d1 = l & ~q;
    lk_d2 = lk_d1; lk_d1 = l;
  endtask

  task automatic step(input logic r, input logic l, input logic q);
    exp_t x;
    reset_n = r; pll_locked = l; ext_rst_req = q;
    model_edge(r, l, q, x);
    exp_q.push_back(x);
    @(negedge clk_sys);
  endtask

  task automatic wait_rise(input string nm);
    int n;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (sys_rst_n === 1'b1) n = i;
    end
    chk_int(nm, n, RST_HOLD + 3);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sys_rst_n", sys_rst_n, e.rst);
        chk("ce_cpu",    ce_cpu,    e.cpu);
        chk("ce_psg",    ce_psg,    e.psg);
        chk("ce_fdc",    ce_fdc,    e.fdc);
        chk("pll_lost",  pll_lost,  e.lost);
      end
    end
  end

  initial begin
    int r, len;
    logic l, q;
    // power-up
    repeat (4) step(1'b0, 1'b1, 1'b0);
    wait_rise("t1_rise_edges");
    // cadence through run cycle 39 and beyond
    repeat (50) step(1'b1, 1'b1, 1'b0);
    // lock loss in run
    repeat (2) step(1'b1, 1'b0, 1'b0);
    chk("t3_rst_before_3rd", sys_rst_n, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("t3_rst_after_3rd", sys_rst_n, 1'b0);
    chk("t3_lost", pll_lost, 1'b1);
    wait_rise("t3_relock_edges");
    repeat (10) step(1'b1, 1'b1, 1'b0);
    // reset mid-run with the sticky flag set
    step(1'b0, 1'b1, 1'b0);
    chk("t6_lost_clear", pll_lost, 1'b0);
    chk("t6_rst_low", sys_rst_n, 1'b0);
    wait_rise("t6_rise_edges");
    repeat (10) step(1'b1, 1'b1, 1'b0);
    // external request
    repeat (3) step(1'b1, 1'b1, 1'b1);
    chk("t5_rst_low", sys_rst_n, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b1);
    wait_rise("t5_release_edges");
    chk("t5_lost_stays", pll_lost, 1'b0);
    // glitch during stretch: request drops to wait, then lock dips at hold_cnt=10
    repeat (3) step(1'b1, 1'b1, 1'b1);
    repeat (13) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    wait_rise("t4_restart_edges");
    chk("t4_lost", pll_lost, 1'b1);
    // randomized segments
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        repeat ($urandom_range(1, 2)) step(1'b0, 1'b1, 1'b0);
      end else begin
        l = 1'b1; q = 1'b0; len = $urandom_range(10, 60);
        if (r < 20) begin l = 1'b0; len = $urandom_range(1, 4); end
        else if (r < 35) begin q = 1'b1; len = $urandom_range(2, 6); end
        repeat (len) step(1'b1, l, q);
      end
    end
    repeat (3) step(1'b1, 1'b1, 1'b0);
    @(negedge clk_sys);
    chk_int("scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
